// File: rtl/ula_pkg.sv
// Shared definitions for the ALU operation sequencer: operand width, opcodes, FSM states.
package ula_pkg;

    localparam int WIDTH = 8;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/somadorde8bits.sv
// 8-bit ripple-carry adder without carry-in; carry out exposed on cout.
module somadorde8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s,
    output logic       cout
);

    logic [8:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]         = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign cout = carry_s[8];

endmodule

// File: rtl/ula_sequenciador.sv
// Multi-cycle ADD/SUB/MUL/PASS sequencer time-sharing one somadorde8bits adder.
// Optional ULA_ZERO_FLAG_EN adds a registered zero output alongside result.
module ula_sequenciador
    import ula_pkg::*;
#(
    parameter int WIDTH = ula_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag,
`ifdef ULA_ZERO_FLAG_EN
    output logic                 zero,
`endif
    output logic                 done
);

    localparam int         MUL_ITER = WIDTH;
    localparam logic [3:0] MUL_LAST = 4'(MUL_ITER - 1);

    if (WIDTH != 8) begin : g_width_check
        $error("ula_sequenciador supports WIDTH=8 only");
    end

    state_t               state_r, state_next_s;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     op_a_r, op_b_r, acc_hi_r, acc_lo_r, tmp_r;
    logic                 c1_r;
    logic [3:0]           count_r;
    logic [2*WIDTH-1:0]   result_r, res_next_s;
    logic                 flag_r, flag_next_s, done_r, last_pass_s;
    logic [WIDTH-1:0]     add_a_s, add_b_s, add_sum_s, mul_hi_s, mul_lo_s;
    logic                 add_cout_s;
`ifdef ULA_ZERO_FLAG_EN
    logic                 zero_r;
`endif

    somadorde8bits u_somador (
        .a    (add_a_s),
        .b    (add_b_s),
        .s    (add_sum_s),
        .cout (add_cout_s)
    );

    // Adder operand selection for the current pass
    always_comb begin
        add_a_s = op_a_r;
        add_b_s = op_b_r;
        case (op_r)
            OP_ADD: begin
                add_a_s = op_a_r;
                add_b_s = op_b_r;
            end
            OP_SUB: begin
                if (count_r == 4'd0) begin
                    add_a_s = ~op_b_r;
                    add_b_s = 8'h01;
                end else begin
                    add_a_s = op_a_r;
                    add_b_s = tmp_r;
                end
            end
            OP_MUL: begin
                add_a_s = acc_hi_r;
                add_b_s = acc_lo_r[0] ? op_a_r : 8'h00;
            end
            default: begin
                add_a_s = op_a_r;
                add_b_s = 8'h00;
            end
        endcase
    end

    // Shift-add step: carry enters the accumulator top, low sum bit shifts into acc_lo
    assign mul_hi_s = {add_cout_s, add_sum_s[WIDTH-1:1]};
    assign mul_lo_s = {add_sum_s[0], acc_lo_r[WIDTH-1:1]};

    // Final result and flag as they would be captured on the last pass
    always_comb begin
        res_next_s  = {{WIDTH{1'b0}}, add_sum_s};
        flag_next_s = 1'b0;
        case (op_r)
            OP_ADD:  flag_next_s = add_cout_s;
            OP_SUB:  flag_next_s = ~(c1_r | add_cout_s);
            OP_MUL: begin
                res_next_s  = {mul_hi_s, mul_lo_s};
                flag_next_s = (mul_hi_s != {WIDTH{1'b0}});
            end
            default: flag_next_s = 1'b0;
        endcase
    end

    // Next-state logic and last-pass detection
    always_comb begin
        state_next_s = state_r;
        last_pass_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = EXEC;
                else       state_next_s = IDLE;
            end
            EXEC: begin
                case (op_r)
                    OP_SUB:  last_pass_s = (count_r == 4'd1);
                    OP_MUL:  last_pass_s = (count_r == MUL_LAST);
                    default: last_pass_s = 1'b1;
                endcase
                if (last_pass_s) state_next_s = FIN;
                else             state_next_s = EXEC;
            end
            FIN:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Operand latch, pass counter, accumulator and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= 2'b00;
            op_a_r   <= 8'h00;
            op_b_r   <= 8'h00;
            acc_hi_r <= 8'h00;
            acc_lo_r <= 8'h00;
            tmp_r    <= 8'h00;
            c1_r     <= 1'b0;
            count_r  <= 4'd0;
            result_r <= 16'h0000;
            flag_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef ULA_ZERO_FLAG_EN
            zero_r   <= 1'b0;
`endif
        end else begin
            done_r <= (state_r == EXEC) && last_pass_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        op_a_r   <= a;
                        op_b_r   <= b;
                        acc_hi_r <= 8'h00;
                        acc_lo_r <= b;
                        count_r  <= 4'd0;
                    end
                end
                EXEC: begin
                    count_r <= count_r + 4'd1;
                    if ((op_r == OP_SUB) && (count_r == 4'd0)) begin
                        c1_r  <= add_cout_s;
                        tmp_r <= add_sum_s;
                    end
                    if (op_r == OP_MUL) begin
                        acc_hi_r <= mul_hi_s;
                        acc_lo_r <= mul_lo_s;
                    end
                    if (last_pass_s) begin
                        result_r <= res_next_s;
                        flag_r   <= flag_next_s;
`ifdef ULA_ZERO_FLAG_EN
                        zero_r   <= (res_next_s == 16'h0000);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = (state_r == IDLE);
    assign done   = done_r;
    assign result = result_r;
    assign flag   = flag_r;
`ifdef ULA_ZERO_FLAG_EN
    assign zero   = zero_r;
`endif

endmodule

// File: tb/tb_ula_sequenciador.sv
// Self-checking bench for ula_sequenciador: vector table, hand-written handshake/reset
// sequences and random operations against an arithmetic reference model.
module tb_ula_sequenciador;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready;
    logic [1:0]  op = 2'b00;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic [15:0] result;
    logic        flag;
    logic        done;
`ifdef ULA_ZERO_FLAG_EN
    logic        zero;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] last_res = 16'h0000;
    logic        last_flag = 1'b0;

    ula_sequenciador dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ready  (ready),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .flag   (flag),
`ifdef ULA_ZERO_FLAG_EN
        .zero   (zero),
`endif
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_res;
        logic        exp_flag;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation's meaning
    task automatic model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         output logic [15:0] er, output logic ef, output int el);
        int s;
        case (o)
            2'b00: begin s = int'(x) + int'(y); er = 16'(s % 256); ef = (s > 255); el = 2; end
            2'b01: begin s = int'(x) - int'(y) + 256; er = 16'(s % 256); ef = (x < y); el = 3; end
            2'b10: begin s = int'(x) * int'(y); er = 16'(s); ef = (s > 255); el = 9; end
            default: begin er = {8'h00, x}; ef = 1'b0; el = 2; end
        endcase
    endtask

    // Wait for done, checking result/flag hold meanwhile; lat counts clocks from accept edge
    task automatic wait_done(input int lat0, output int lat, output bit seen);
        lat = lat0;
        seen = 1'b0;
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1'b1;
            end else begin
                check("hold_result", result, last_res);
                check("hold_flag", 16'(flag), 16'(last_flag));
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done after %0d clocks expected done", lat);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] er, input logic ef,
                                 input int el, input int lat);
        check({tag, "_lat"}, 16'(lat), 16'(el));
        check({tag, "_result"}, result, er);
        check({tag, "_flag"}, 16'(flag), 16'(ef));
`ifdef ULA_ZERO_FLAG_EN
        check({tag, "_zero"}, 16'(zero), 16'(er == 16'h0000));
`endif
        last_res  = er;
        last_flag = ef;
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [15:0] er, input logic ef, input int el);
        int lat;
        bit seen;
        @(negedge clk);
        check({tag, "_ready"}, 16'(ready), 16'd1);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
        wait_done(0, lat, seen);
        if (seen) check_outputs(tag, er, ef, el, lat);
        @(negedge clk);
        check({tag, "_done_pulse"}, 16'(done), 16'd0);
        check({tag, "_idle"}, 16'(ready), 16'd1);
    endtask

    initial begin
        vec_t vecs[10];
        logic [1:0]  ro;
        logic [7:0]  rx, ry;
        logic [15:0] er;
        logic        ef;
        int          el, lat;
        bit          seen;

        vecs[0] = '{2'b00, 8'hF0, 8'h20, 16'h0010, 1'b1, 2};
        vecs[1] = '{2'b01, 8'h05, 8'h07, 16'h00FE, 1'b1, 3};
        vecs[2] = '{2'b01, 8'h07, 8'h00, 16'h0007, 1'b0, 3};
        vecs[3] = '{2'b10, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 9};
        vecs[4] = '{2'b10, 8'h0C, 8'h0A, 16'h0078, 1'b0, 9};
        vecs[5] = '{2'b11, 8'hA5, 8'h3C, 16'h00A5, 1'b0, 2};
        vecs[6] = '{2'b00, 8'h7F, 8'h01, 16'h0080, 1'b0, 2};
        vecs[7] = '{2'b01, 8'h07, 8'h05, 16'h0002, 1'b0, 3};
        vecs[8] = '{2'b10, 8'h00, 8'hFF, 16'h0000, 1'b0, 9};
        vecs[9] = '{2'b10, 8'h10, 8'h10, 16'h0100, 1'b1, 9};

        #1;
        check("reset_ready", 16'(ready), 16'd1);
        check("reset_done", 16'(done), 16'd0);
        check("reset_result", result, 16'h0000);
        check("reset_flag", 16'(flag), 16'd0);
`ifdef ULA_ZERO_FLAG_EN
        check("reset_zero", 16'(zero), 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp_res, vecs[i].exp_flag, vecs[i].exp_lat);

        // Start pulse during MUL execution must be ignored
        @(negedge clk);
        op = 2'b10; a = 8'h0D; b = 8'h0B; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_ready", 16'(ready), 16'd0);
        op = 2'b00; a = 8'h01; b = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1, lat, seen);
        if (seen) check_outputs("busy_mul", 16'h008F, 1'b0, 9, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("busy_no_queue_done", 16'(done), 16'd0);
            check("busy_no_queue_ready", 16'(ready), 16'd1);
        end

        // Start held high: second op accepted in the IDLE cycle after done
        @(negedge clk);
        op = 2'b00; a = 8'h10; b = 8'h22; start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(0, lat, seen);
        if (seen) check_outputs("held_first", 16'h0032, 1'b0, 2, lat);
        op = 2'b01; a = 8'h40; b = 8'h01;
        @(negedge clk);
        check("held_idle_ready", 16'(ready), 16'd1);
        check("held_idle_done", 16'(done), 16'd0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, lat, seen);
        if (seen) check_outputs("held_second", 16'h003F, 1'b0, 3, lat);

        // Reset after four MUL passes aborts with no done
        @(negedge clk);
        op = 2'b10; a = 8'h0C; b = 8'h0A; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", 16'(ready), 16'd1);
        check("abort_result", result, 16'h0000);
        check("abort_flag", 16'(flag), 16'd0);
        check("abort_done", 16'(done), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = 16'h0000;
        last_flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", 16'(done), 16'd0);
        end
        do_op("after_abort", 2'b00, 8'h01, 8'h01, 16'h0002, 1'b0, 2);

        // Zero result and its clearing
        do_op("sub_equal", 2'b01, 8'h33, 8'h33, 16'h0000, 1'b0, 3);
        do_op("add_nonzero", 2'b00, 8'h01, 8'h00, 16'h0001, 1'b0, 2);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            rx = 8'($urandom);
            ry = 8'($urandom);
            model(ro, rx, ry, er, ef, el);
            do_op($sformatf("rand%0d_op%0d_%0h_%0h", i, ro, rx, ry), ro, rx, ry, er, ef, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
